md_sched: RTL and testbench

Multiply/divide sequencer for the Execute stage of the five-stage MIPS pipeline. It accepts one MD operation per request, holds the pipeline off via `busy` for a fixed per-operation latency, and then commits the 64-bit result to the HI/LO registers. The Decode-stage hazard logic stalls any MD-class instruction while `start || busy`. `mfhi`/`mflo` read `hi`/`lo` directly in Execute.

---
 rtl/md_sched.sv | 135 +++++++++++++
 tb/tb_md_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide sequencer for the Execute stage: computes the 64-bit result at issue,
// holds busy for a fixed per-operation latency, then commits the result to HI/LO.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opt,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CntW = 4;
    localparam int unsigned DataW = 32;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, stateNext;
    logic [CntW-1:0]   cnt, cntNext;
    logic [DataW-1:0]  phi, phiNext, plo, ploNext, hiNext, loNext;
    logic              pvalid, pvalidNext, doneNext;

    logic [2*DataW-1:0] mulA, mulB, prod;
    logic               divSigned, divByZero;
    logic [DataW-1:0]   magA, magB, uq, ur, quo, rem;

    // Product: the low 64 bits of a 64x64 multiply of extended operands equal the 32x32 product.
    always_comb begin
        mulA = (opt == OpMult) ? {{DataW{v1[31]}}, v1} : {{DataW{1'b0}}, v1};
        mulB = (opt == OpMult) ? {{DataW{v2[31]}}, v2} : {{DataW{1'b0}}, v2};
        prod = mulA * mulB;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        divSigned = (opt == OpDiv);
        divByZero = (v2 == '0);
        magA = (divSigned && v1[31]) ? (~v1 + DataW'(1)) : v1;
        if (divByZero)
            magB = DataW'(1);
        else
            magB = (divSigned && v2[31]) ? (~v2 + DataW'(1)) : v2;
        uq  = magA / magB;
        ur  = magA % magB;
        quo = (divSigned && (v1[31] ^ v2[31])) ? (~uq + DataW'(1)) : uq;
        rem = (divSigned && v1[31]) ? (~ur + DataW'(1)) : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            phi    <= '0;
            plo    <= '0;
            pvalid <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            phi    <= phiNext;
            plo    <= ploNext;
            pvalid <= pvalidNext;
            hi     <= hiNext;
            lo     <= loNext;
            done   <= doneNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        phiNext    = phi;
        ploNext    = plo;
        pvalidNext = pvalid;
        hiNext     = hi;
        loNext     = lo;
        doneNext   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (opt)
                        OpMult, OpMultu: begin
                            {phiNext, ploNext} = prod;
                            cntNext    = CntW'(MULT_CYCLES);
                            pvalidNext = 1'b1;
                            stateNext  = RUN;
                        end
                        OpDiv, OpDivu: begin
                            phiNext    = rem;
                            ploNext    = quo;
                            cntNext    = CntW'(DIV_CYCLES);
                            pvalidNext = !divByZero;
                            stateNext  = RUN;
                        end
                        OpMthi:  hiNext = v1;
                        OpMtlo:  loNext = v1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cntNext = cnt - CntW'(1);
                // Commit edge; <= also guards an unreachable zero count from locking up.
                if (cnt <= CntW'(1)) begin
                    if (pvalid) begin
                        hiNext = phi;
                        loNext = plo;
                    end
                    cntNext   = '0;
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares on every done pulse.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  opt;
    logic [31:0] v1, v2;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sbQ[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned busyRun = 0;
    int unsigned doneSeen = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .opt(opt),
        .v1(v1), .v2(v2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: busy length and HI/LO checked against the scoreboard at each done.
    always @(negedge clk) begin
        if (reset) begin
            busyRun = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                doneSeen++;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0 hi=%h lo=%h", hi, lo);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    chk("sb_hi", 64'(hi), 64'(e.hi));
                    chk("sb_lo", 64'(lo), 64'(e.lo));
                    chk("sb_busy_cycles", 64'(busyRun), 64'(e.cyc));
                end
                busyRun = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] h, logic [31:0] l, int unsigned c);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = c;
        sbQ.push_back(e);
    endtask

    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        start = 1'b1; opt = o; v1 = a; v2 = b;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
    endtask

    initial begin
        int unsigned doneBefore;
        reset = 1'b1; start = 1'b0; opt = 3'b110; v1 = '0; v2 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);

        // mult -1 * 2
        push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        issue(3'b000, 32'hFFFFFFFF, 32'd2);
        chk("mult_busy", 64'(busy), 64'h1);
        waitDone();

        // multu back-to-back with done
        push(32'hFFFFFFFE, 32'h00000001, 5);
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone();

        // div -7 / 2
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        waitDone();

        // div overflow corner
        push(32'h00000000, 32'h80000000, 10);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        waitDone();

        // divu by zero: full latency, HI/LO unchanged
        push(32'h00000000, 32'h80000000, 10);
        issue(3'b011, 32'd7, 32'd0);
        waitDone();

        // mthi then mtlo on consecutive cycles
        issue(3'b100, 32'h12345678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h12345678);
        chk("mthi_lo", 64'(lo), 64'h80000000);
        chk("mthi_busy", 64'(busy), 64'h0);
        issue(3'b101, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        chk("mtlo_hi", 64'(hi), 64'h12345678);
        chk("mtlo_busy", 64'(busy), 64'h0);
        chk("mtlo_done", 64'(done), 64'h0);

        // mult 3*4 with start held as mthi during RUN
        push(32'h00000000, 32'd12, 5);
        start = 1'b1; opt = 3'b000; v1 = 32'd3; v2 = 32'd4;
        tick();
        opt = 3'b100; v1 = 32'h0000DEAD; v2 = 32'd0;
        begin
            int n = 0;
            while (!done && n < 40) begin
                if (busy) chk("held_hi", 64'(hi), 64'h12345678);
                tick();
                n++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL held_done_timeout actual=0 expected=1");
            end
        end
        // div issued in the done cycle: 100 / 7 = 14 rem 2
        push(32'd2, 32'd14, 10);
        opt = 3'b010; v1 = 32'd100; v2 = 32'd7;
        tick();
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'h1);
        waitDone();

        // reset at busy cycle 3 of a div
        tick();
        issue(3'b010, 32'd9, 32'd2);
        tick(); tick();
        chk("pre_rst_busy", 64'(busy), 64'h1);
        doneBefore = doneSeen;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_hi", 64'(hi), 64'h0);
        chk("midrst_lo", 64'(lo), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        repeat (15) tick();
        chk("midrst_no_done", 64'(doneSeen), 64'(doneBefore));
        chk("midrst_hi_after", 64'(hi), 64'h0);

        chk("sb_empty", 64'(sbQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
